// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory arbiter: the FSM state
// encoding, bus widths, the default lock limit and a counter sizing helper.
package riscv_pkg;

    localparam int XLEN             = 32;
    localparam int F3_W             = 3;
    localparam int MAX_LOCK_DEFAULT = 8;

    // IDLE: round-robin between requesters.
    // LOCK0/LOCK1: the named requester keeps the port while it keeps asking.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // Bits needed to hold a count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the data memory.
// The slave side is the arbiter; the master side is everything around it
// (requester 0 = core, requester 1 = loader/debug, plus the memory array).
interface dmem_arbiter_if;
    import riscv_pkg::*;

    // Requester 0 (core)
    logic            req0;
    logic            we0;
    logic [XLEN-1:0] addr0;
    logic [XLEN-1:0] wdata0;
    logic [F3_W-1:0] func3_0;
    logic            lock0;
    logic            gnt0;
    logic            rvalid0;
    logic [XLEN-1:0] rdata0;

    // Requester 1 (loader/debug)
    logic            req1;
    logic            we1;
    logic [XLEN-1:0] addr1;
    logic [XLEN-1:0] wdata1;
    logic [F3_W-1:0] func3_1;
    logic            lock1;
    logic            gnt1;
    logic            rvalid1;
    logic [XLEN-1:0] rdata1;

    // Data memory port
    logic            mem_we;
    logic [XLEN-1:0] mem_a;
    logic [XLEN-1:0] mem_wd;
    logic [F3_W-1:0] mem_func3;
    logic [XLEN-1:0] mem_rd;

    modport slave (
        input  req0, we0, addr0, wdata0, func3_0, lock0,
        input  req1, we1, addr1, wdata1, func3_1, lock1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_we, mem_a, mem_wd, mem_func3,
        input  mem_rd
    );

    modport master (
        output req0, we0, addr0, wdata0, func3_0, lock0,
        output req1, we1, addr1, wdata1, func3_1, lock1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_we, mem_a, mem_wd, mem_func3,
        output mem_rd
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. last names the requester served most recently;
// on a tie the other one wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester wins outright; a tie goes to the side not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one data-memory port between the core (0) and the
// loader/debug port (1). Grants are combinational; a requester may hold the
// port with lock, bounded by MAX_LOCK grants while the other side waits.
// Load data is registered and returned one cycle after the grant.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(MAX_LOCK);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic             last_gnt;
    logic             last_gnt_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;

    logic [1:0]       req;
    logic [1:0]       rr_gnt;
    logic [1:0]       gnt;
    logic             force_switch;
    logic             other_req;
    logic             same_owner;

    logic [1:0]       rvalid_q;
    logic [XLEN-1:0]  rdata0_q;
    logic [XLEN-1:0]  rdata1_q;

    logic             mem_we_c;
    logic [XLEN-1:0]  mem_a_c;
    logic [XLEN-1:0]  mem_wd_c;
    logic [F3_W-1:0]  mem_func3_c;

    assign req = {bus.req1, bus.req0};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_gnt),
        .gnt  (rr_gnt)
    );

    // The lock owner has used up its turn; the waiting side goes next.
    assign force_switch = (lock_cnt >= CNT_W'(MAX_LOCK));

    // Grant and next state. Reset gates the grant so nothing reaches memory
    // while rst is low, even in the middle of a cycle.
    always_comb begin
        gnt       = 2'b00;
        state_nxt = IDLE;
        if (rst) begin
            case (state)
                LOCK0:   gnt = (req[0] && !force_switch) ? 2'b01 : rr_gnt;
                LOCK1:   gnt = (req[1] && !force_switch) ? 2'b10 : rr_gnt;
                default: gnt = rr_gnt;
            endcase

            if ((state == LOCK0 && !req[0]) || (state == LOCK1 && !req[1])) begin
                state_nxt = IDLE;
            end else if (gnt[0] && bus.lock0) begin
                state_nxt = LOCK0;
            end else if (gnt[1] && bus.lock1) begin
                state_nxt = LOCK1;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // Lock counter and round-robin history: the counter tracks back-to-back
    // grants to one owner while the other side is waiting.
    always_comb begin
        other_req    = (gnt[0] & req[1]) | (gnt[1] & req[0]);
        same_owner   = (gnt[0] & ~last_gnt) | (gnt[1] & last_gnt);
        lock_cnt_nxt = '0;
        if (other_req) begin
            if (!same_owner) begin
                lock_cnt_nxt = CNT_W'(1);
            end else if (lock_cnt != CNT_W'(MAX_LOCK)) begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end else begin
                lock_cnt_nxt = lock_cnt;
            end
        end

        last_gnt_nxt = last_gnt;
        if (gnt[1]) begin
            last_gnt_nxt = 1'b1;
        end else if (gnt[0]) begin
            last_gnt_nxt = 1'b0;
        end
    end

    // State, history and lock count registers; requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Memory port mux: the granted requester drives it, otherwise all zero.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_a_c     = '0;
        mem_wd_c    = '0;
        mem_func3_c = '0;
        if (gnt[0]) begin
            mem_we_c    = bus.we0;
            mem_a_c     = bus.addr0;
            mem_wd_c    = bus.wdata0;
            mem_func3_c = bus.func3_0;
        end else if (gnt[1]) begin
            mem_we_c    = bus.we1;
            mem_a_c     = bus.addr1;
            mem_wd_c    = bus.wdata1;
            mem_func3_c = bus.func3_1;
        end
    end

    // Load return: capture memory data on a granted load, pulse rvalid once;
    // rdata keeps its value until that requester's next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= gnt & ~{bus.we1, bus.we0};
            if (gnt[0] && !bus.we0) begin
                rdata0_q <= bus.mem_rd;
            end
            if (gnt[1] && !bus.we1) begin
                rdata1_q <= bus.mem_rd;
            end
        end
    end

    assign bus.gnt0      = gnt[0];
    assign bus.gnt1      = gnt[1];
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_a     = mem_a_c;
    assign bus.mem_wd    = mem_wd_c;
    assign bus.mem_func3 = mem_func3_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a driver issues one request pair per cycle and
// pushes the expected port activity and load returns into queues; a monitor
// on the falling edge pops and compares them against the DUT.
module tb_dmem_arbiter;
    import riscv_pkg::*;

    localparam int ML = MAX_LOCK_DEFAULT;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        lock;
    } rq_t;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
    } cyc_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_LOCK(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory array behind the arbiter
    logic [31:0] mem [256];
    bit          mem_ok;

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ok <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[9:2]] <= bus.mem_wd;
        end
    end

    assign bus.mem_rd = mem[bus.mem_a[9:2]];

    // Scoreboard
    cyc_t exp_q [$];
    rd_t  rdq0 [$];
    rd_t  rdq1 [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns the port, how long it has kept it while the
    // other side waited, and who was served last.
    logic [31:0] ref_mem [256];
    int m_lock   = -1;
    int m_streak = 0;
    int m_last   = 1;

    task automatic model_reset();
        m_lock   = -1;
        m_streak = 0;
        m_last   = 1;
        rdq0.delete();
        rdq1.delete();
    endtask

    function automatic int model_pick(input bit [1:0] rq);
        if (m_lock >= 0 && rq[m_lock] && !(m_streak >= ML && rq[1 - m_lock])) return m_lock;
        if (rq == 2'b11) return 1 - m_last;
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g, input bit [1:0] rq, input bit [1:0] lk);
        if (g < 0)            m_streak = 0;
        else if (rq[1 - g])   m_streak = (g == m_last) ? m_streak + 1 : 1;
        else                  m_streak = 0;
        if (m_lock >= 0 && !rq[m_lock]) m_lock = -1;
        else if (g >= 0 && lk[g])       m_lock = g;
        else                            m_lock = -1;
        if (g >= 0) m_last = g;
    endtask

    // One cycle of stimulus plus the expectations it implies.
    task automatic drive(input rq_t a, input rq_t b, input logic rst_val, input bit mid_rst);
        cyc_t     e;
        rq_t      rg;
        rd_t      x;
        bit [1:0] rq;
        bit [1:0] lk;
        int       g;
        @(posedge clk);
        #1;
        rst         = rst_val;
        bus.req0    = a.req;   bus.we0 = a.we;   bus.addr0 = a.addr;
        bus.wdata0  = a.wdata; bus.func3_0 = a.f3; bus.lock0 = a.lock;
        bus.req1    = b.req;   bus.we1 = b.we;   bus.addr1 = b.addr;
        bus.wdata1  = b.wdata; bus.func3_1 = b.f3; bus.lock1 = b.lock;
        e  = '0;
        rq = {b.req, a.req};
        lk = {b.lock, a.lock};
        if (!rst_val) begin
            model_reset();
        end else begin
            g  = model_pick(rq);
            rg = (g == 1) ? b : a;
            if (mid_rst) begin
                #1;
                check("pre_rst_mem_we", 32'(bus.mem_we), 32'(g >= 0 && rg.we));
                rst = 1'b0;
                #1;
                check("rst_mem_we", 32'(bus.mem_we), 32'd0);
                check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
                model_reset();
            end else begin
                if (g >= 0) begin
                    e.g0 = (g == 0);
                    e.g1 = (g == 1);
                    e.we = rg.we;
                    e.a  = rg.addr;
                    e.wd = rg.wdata;
                    e.f3 = rg.f3;
                    if (rg.we) begin
                        ref_mem[rg.addr[9:2]] = rg.wdata;
                    end else begin
                        x.cyc  = cyc;
                        x.data = ref_mem[rg.addr[9:2]];
                        if (g == 0) rdq0.push_back(x);
                        else        rdq1.push_back(x);
                    end
                end
                model_update(g, rq, lk);
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare port activity every cycle and load returns as they come.
    logic [31:0] hold0;
    logic [31:0] hold1;
    always @(negedge clk) begin : mon
        cyc_t e;
        rd_t  x;
        if (!rst) begin
            hold0 = '0;
            hold1 = '0;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt0",      32'(bus.gnt0),      32'(e.g0));
            check("gnt1",      32'(bus.gnt1),      32'(e.g1));
            check("mem_we",    32'(bus.mem_we),    32'(e.we));
            check("mem_a",     bus.mem_a,          e.a);
            check("mem_wd",    bus.mem_wd,         e.wd);
            check("mem_func3", 32'(bus.mem_func3), 32'(e.f3));
        end
        if (rdq0.size() > 0 && rdq0[0].cyc + 1 == cyc) begin
            x = rdq0.pop_front();
            check("rvalid0", 32'(bus.rvalid0), 32'd1);
            check("rdata0",  bus.rdata0, x.data);
            hold0 = x.data;
        end else begin
            check("rvalid0_quiet", 32'(bus.rvalid0), 32'd0);
            check("rdata0_hold",   bus.rdata0, hold0);
        end
        if (rdq1.size() > 0 && rdq1[0].cyc + 1 == cyc) begin
            x = rdq1.pop_front();
            check("rvalid1", 32'(bus.rvalid1), 32'd1);
            check("rdata1",  bus.rdata1, x.data);
            hold1 = x.data;
        end else begin
            check("rvalid1_quiet", 32'(bus.rvalid1), 32'd0);
            check("rdata1_hold",   bus.rdata1, hold1);
        end
    end

    function automatic rq_t mk(input bit req, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit lock);
        rq_t r;
        r.req   = req;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.f3    = 3'b010;
        r.lock  = lock;
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    function automatic rq_t rnd_rq(input int req_pct, input int lock_pct);
        rq_t r;
        r.req   = ($urandom_range(0, 99) < req_pct);
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = rnd_addr();
        r.wdata = $urandom;
        r.f3    = 3'($urandom_range(0, 7));
        r.lock  = ($urandom_range(0, 99) < lock_pct);
        return r;
    endfunction

    rq_t idle_rq;

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.func3_0 = '0; bus.lock0 = 1'b0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.func3_1 = '0; bus.lock1 = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        idle_rq = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Held in reset with both sides requesting: port must stay silent.
        for (int i = 0; i < 3; i++)
            drive(mk(1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1),
                  mk(1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b1), 1'b0, 1'b0);

        // Both loading, no lock: 0, 1, 0, 1 ...
        for (int i = 0; i < 6; i++)
            drive(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0), mk(1'b1, 1'b0, 32'h20, 32'h0, 1'b0), 1'b1, 1'b0);
        drive(idle_rq, idle_rq, 1'b1, 1'b0);

        // Store from loader, read back by the core.
        drive(idle_rq, mk(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0), 1'b1, 1'b0);
        drive(mk(1'b1, 1'b0, 32'h40, 32'h0, 1'b0), idle_rq, 1'b1, 1'b0);
        drive(idle_rq, idle_rq, 1'b1, 1'b0);

        // Serve requester 1 last, then core locks while loader waits.
        drive(idle_rq, mk(1'b1, 1'b0, 32'h08, 32'h0, 1'b0), 1'b1, 1'b0);
        drive(idle_rq, idle_rq, 1'b1, 1'b0);
        for (int i = 0; i < ML + 2; i++)
            drive(mk(1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b1), mk(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0), 1'b1, 1'b0);

        // Core drops its request mid-lock: loader served at once, then IDLE.
        drive(idle_rq, mk(1'b1, 1'b0, 32'h14, 32'h0, 1'b0), 1'b1, 1'b0);
        drive(mk(1'b1, 1'b0, 32'h18, 32'h0, 1'b0), mk(1'b1, 1'b0, 32'h1C, 32'h0, 1'b0), 1'b1, 1'b0);

        // Nobody asking, address/data lines still toggling.
        for (int i = 0; i < 5; i++)
            drive(mk(1'b0, 1'b1, $urandom, $urandom, 1'b1), mk(1'b0, 1'b1, $urandom, $urandom, 1'b1), 1'b1, 1'b0);

        // Reset lands during a loader store, with a core load return pending.
        drive(mk(1'b1, 1'b0, 32'h44, 32'h0, 1'b0), idle_rq, 1'b1, 1'b0);
        drive(idle_rq, mk(1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b0), 1'b1, 1'b1);
        drive(idle_rq, mk(1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b0), 1'b0, 1'b0);
        drive(idle_rq, idle_rq, 1'b1, 1'b0);
        check("mem80_untouched", mem[32], ref_mem[32]);
        drive(idle_rq, mk(1'b1, 1'b0, 32'h80, 32'h0, 1'b0), 1'b1, 1'b0);

        // Random traffic with occasional locking.
        for (int i = 0; i < 400; i++)
            drive(rnd_rq(70, 35), rnd_rq(70, 35), 1'b1, 1'b0);

        // Drain and make sure every expected load came back.
        for (int i = 0; i < 3; i++) drive(idle_rq, idle_rq, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("rdq0_left", 32'(rdq0.size()), 32'd0);
        check("rdq1_left", 32'(rdq1.size()), 32'd0);
        check("expq_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
